// File: rtl/if_fetch_unit.sv
// if_fetch_unit: in-order instruction fetch with credit-based issue, response buffering and flush.
module if_fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            fetch_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [CW-1:0] occ, out_cnt, drop_cnt;
  logic [CW:0] used;
  logic [PW-1:0] rq_wp, rq_rp, wp, rp;
  logic [XLEN-1:0] rq_pc [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc [DEPTH];
  logic fire, rsp, keep, pop;
  always_comb begin
    used = {1'b0, occ} + {1'b0, out_cnt};
    imem_req_valid = !rst && !flush && (used < (CW+1)'(DEPTH));
    imem_req_addr = pc_in;
    fire = imem_req_valid && imem_req_ready;
    fetch_stall = !rst && !flush && !fire;
    rsp = !rst && imem_rsp_valid && (out_cnt != '0);
    keep = rsp && (drop_cnt == '0) && !flush;
    id_valid = occ != '0;
    id_instr = id_valid ? buf_instr[rp] : NOP;
    id_pc = id_valid ? buf_pc[rp] : '0;
    pop = id_valid && id_ready;
  end
  always_ff @(posedge clk) begin
    if (fire) rq_pc[rq_wp] <= pc_in;
    if (keep) begin
      buf_instr[wp] <= imem_rsp_data;
      buf_pc[wp] <= rq_pc[rq_rp];
    end
  end
  // a flush turns every still-unanswered request into one to be discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      out_cnt <= '0;
      drop_cnt <= '0;
      rq_wp <= '0;
      rq_rp <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      rq_wp <= rq_wp + PW'(fire);
      rq_rp <= rq_rp + PW'(rsp);
      out_cnt <= out_cnt + CW'(fire) - CW'(rsp);
      if (flush) begin
        drop_cnt <= out_cnt - CW'(rsp);
        occ <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        drop_cnt <= drop_cnt - CW'(rsp && drop_cnt != '0);
        occ <= occ + CW'(keep) - CW'(pop);
        wp <= wp + PW'(keep);
        rp <= rp + PW'(pop);
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> out_cnt != '0);
  assert property (@(posedge clk) disable iff (rst) used <= (CW+1)'(DEPTH) && drop_cnt <= out_cnt);
endmodule
